// File: rtl/trigger_hit_unit_pkg.sv
// trigger_pkg: shared action/state encodings and default sizes for the trigger hit unit
package trigger_pkg;
  localparam int DEF_NUM_TRIGGERS = 4;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [3:0] {ACT_BKPT = 4'd0, ACT_DEBUG = 4'd1} trig_action_e;
  typedef enum logic [1:0] {IDLE, REQ, DEBUG} trig_state_e;
endpackage

// File: rtl/trigger_hit_unit_if.sv
// trigger_hit_unit_if: action request handshake between the trigger hit unit and the core
interface trigger_hit_unit_if #(parameter int NT = 4);
  localparam int IW = NT > 1 ? $clog2(NT) : 1;
  logic req_valid;
  logic req_ready;
  logic [IW-1:0] req_index;
  logic [3:0] req_action;
  modport master(output req_valid, req_index, req_action, input req_ready);
  modport slave(input req_valid, req_index, req_action, output req_ready);
endinterface

// File: rtl/trigger_hit_unit_chain_eval.sv
// trigger_chain_eval: per-trigger raw match, chain grouping and group match reported at each group end
module trigger_chain_eval #(
  parameter int NT = 4,
  parameter int NS = 4,
  localparam int SW = NS > 1 ? $clog2(NS) : 1,
  localparam int IW = NT > 1 ? $clog2(NT) : 1
) (
  input  logic [NT-1:0][NS-1:0] match_i,
  input  logic [NT-1:0]         trig_en,
  input  logic [NT-1:0]         trig_chain,
  input  logic [NT-1:0][SW-1:0] trig_slot_sel,
  output logic [NT-1:0]         grp_end,
  output logic [NT-1:0]         grp_match,
  output logic [NT-1:0][IW-1:0] end_idx
);
  logic [NT-1:0] raw, chn, pre;
  logic run;
  logic [IW-1:0] cur;
  always_comb begin
    raw = '0;
    chn = '0;
    pre = '0;
    run = 1'b1;
    grp_end = '0;
    grp_match = '0;
    for (int i = 0; i < NT; i++) begin
      for (int s = 0; s < NS; s++)
        if (int'(trig_slot_sel[i]) == s && match_i[i][s]) raw[i] = trig_en[i];
      chn[i] = trig_chain[i] && i != NT - 1;
      // pre[i]: every member from the group start up to i matched
      pre[i] = raw[i] && run;
      run = !chn[i] || pre[i];
      grp_end[i] = !chn[i];
      grp_match[i] = pre[i] && !chn[i];
    end
  end
  always_comb begin
    end_idx = '0;
    cur = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (!chn[i]) cur = IW'(i);
      end_idx[i] = cur;
    end
  end
endmodule

// File: rtl/trigger_hit_unit.sv
// trigger_hit_unit: resolves comparator matches into sticky hits and one prioritised action request; hit counter under TRIG_HIT_COUNT_EN
module trigger_hit_unit
  import trigger_pkg::*;
#(
  parameter int NUM_TRIGGERS = DEF_NUM_TRIGGERS,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CNT_W = DEF_CNT_W,
  localparam int NT = NUM_TRIGGERS,
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1,
  localparam int IW = NT > 1 ? $clog2(NT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NT-1:0][NUM_SLOTS-1:0] match_i,
  input  logic                        match_valid,
  input  logic [NT-1:0]               trig_en,
  input  logic [NT-1:0]               trig_chain,
  input  logic [NT-1:0][3:0]          trig_action,
  input  logic [NT-1:0][SW-1:0]       trig_slot_sel,
  input  logic [NT-1:0][CNT_W-1:0]    count_limit,
  input  logic [NT-1:0]               hit_clr,
  output logic [NT-1:0]               hit,
  trigger_hit_unit_if.master          bus,
  input  logic                        debug_resume,
  output logic                        in_debug
);
  trig_state_e state, state_nxt;
  logic [NT-1:0] grp_end, grp_match, fire, hit_set;
  logic [NT-1:0][IW-1:0] end_idx;
  logic eval, hold, req_fire;
  logic [IW-1:0] win_idx;
  trigger_chain_eval #(.NT(NT), .NS(NUM_SLOTS)) u_eval (
    .match_i(match_i),
    .trig_en(trig_en),
    .trig_chain(trig_chain),
    .trig_slot_sel(trig_slot_sel),
    .grp_end(grp_end),
    .grp_match(grp_match),
    .end_idx(end_idx)
  );
  assign hold = state == REQ && !bus.req_ready;
  // a breakpoint handshake may evaluate again in the same cycle; a debug handshake may not
  assign eval = match_valid && (state == IDLE ||
                (state == REQ && bus.req_ready && bus.req_action == ACT_BKPT));
`ifdef TRIG_HIT_COUNT_EN
  localparam logic [CNT_W:0] ONE = 1;
  logic [NT-1:0][CNT_W-1:0] cnt;
  logic [NT-1:0] lim_ok;
  always_comb begin
    lim_ok = '0;
    for (int k = 0; k < NT; k++) lim_ok[k] = {1'b0, cnt[k]} + ONE >= {1'b0, count_limit[k]};
  end
  always_ff @(posedge clk)
    for (int k = 0; k < NT; k++)
      if (!rst || !trig_en[k] || !grp_end[k]) cnt[k] <= '0;
      else if (eval && grp_match[k]) cnt[k] <= lim_ok[k] ? '0 : &cnt[k] ? cnt[k] : cnt[k] + CNT_W'(1);
  assign fire = eval ? grp_match & lim_ok : '0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{count_limit, grp_end};
  assign fire = eval ? grp_match : '0;
`endif
  // descending scan so the lowest requesting group is the one left standing
  always_comb begin
    hit_set = '0;
    req_fire = 1'b0;
    win_idx = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      hit_set[i] = fire[end_idx[i]];
      if (fire[i] && trig_action[i] <= ACT_DEBUG) begin
        req_fire = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = req_fire ? REQ : IDLE;
    else if (state == REQ)
      state_nxt = !bus.req_ready ? REQ : bus.req_action == ACT_DEBUG ? DEBUG : req_fire ? REQ : IDLE;
    else state_nxt = debug_resume ? IDLE : DEBUG;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      hit <= '0;
      bus.req_index <= '0;
      bus.req_action <= '0;
    end else begin
      state <= state_nxt;
      if (!hold) hit <= (hit & ~hit_clr) | hit_set;
      if (req_fire) begin
        bus.req_index <= win_idx;
        bus.req_action <= trig_action[win_idx];
      end
    end
  assign bus.req_valid = state == REQ;
  assign in_debug = state == DEBUG;
endmodule
